mem_ctrl_ws: RTL

Parametrised successor to the datapath memory subsystem (MAR/MDR plus RAM). It adds a request/done handshake, a configurable wait-state counter and out-of-range address detection, and is parametrised in data width, address width and depth. It sits between the shared datapath bus and the control unit. The control unit issues read or write requests and waits for `done` before sequencing the next step; the datapath bus mux drives `mdr_q` onto the bus under `MDRout`, outside this block.

---
 rtl/mem_ctrl_ws.sv | 105 ++++++++++
 1 files changed

// File: rtl/mem_ctrl_ws.sv
// MAR/MDR register pair in front of a single-port RAM, with a request/done
// handshake, a configurable wait-state counter and out-of-range detection.
module mem_ctrl_ws #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              rd_req,
  input  logic              wr_req,
  output logic              busy,
  output logic              done,
  output logic              addr_err,
  output logic [ADDR_W-1:0] mar_q,
  output logic [DATA_W-1:0] mdr_q
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is representable in the compare.
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_op_q, wr_op_d;
  logic [ADDR_W-1:0] mar_d;
  logic [DATA_W-1:0] mdr_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;
  logic              mem_we;

  assign in_range = ({1'b0, mar_q} < DEPTH_L);
  // Gated by clr so a reset landing on the ACCESS exit edge aborts the write.
  assign mem_we   = clr && (state_q == S_ACCESS) && wr_op_q && in_range;

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign addr_err = done && !in_range;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_op_d = wr_op_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    case (state_q)
      S_IDLE: begin
        if (MARin) mar_d = bus_in[ADDR_W-1:0];
        if (MDRin) mdr_d = bus_in;
        if (rd_req || wr_req) begin
          wr_op_d = wr_req;
          if (WAIT_STATES == 0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: begin
        if (!wr_op_q) mdr_d = in_range ? mem[mar_q[IDX_W-1:0]] : '0;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_op_q <= 1'b0;
      mar_q   <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_op_q <= wr_op_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
    end
  end

  // NOTE: the RAM array has no reset; clearing it would need a write port per
  // word, and its contents must survive clr anyway.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mar_q[IDX_W-1:0]] <= mdr_q;
  end

endmodule
